// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file: one byte-enabled write port, registered reads with
// write-first bypass, and a per-register busy scoreboard used for decode-stage hazard checks.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int NREG  = 2**ADDR_W;
    localparam int NBYTE = DATA_W/8;

    // Byte-lane merge of new data over the old word, lane k selected by be[k].
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NBYTE-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < NBYTE; k++) begin
            if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok_p0;
    logic              sb_ok_p0;
    logic [DATA_W-1:0] wr_word_p0;
    logic [NREG-1:0]   busy_next_p0;
    logic [NUM_RD*DATA_W-1:0] rd_data_p0;
    logic [NUM_RD-1:0]        rd_busy_p0;

    // Stage p0: qualify write/set, build the post-edge view of the file.
    always_comb begin
        wr_ok_p0   = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
        sb_ok_p0   = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));
        wr_word_p0 = merge_bytes(regs[wr_addr], wr_data, wr_be);
    end

    // Set is applied after clear so a simultaneous issue keeps the register busy.
    always_comb begin
        busy_next_p0 = busy_vec;
        if (wr_ok_p0) busy_next_p0[wr_addr] = 1'b0;
        if (sb_ok_p0) busy_next_p0[sb_addr] = 1'b1;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data_p0[i*DATA_W +: DATA_W] = regs[ra];
            rd_busy_p0[i]                  = busy_next_p0[ra];
            if (wr_ok_p0 && (wr_addr == ra)) rd_data_p0[i*DATA_W +: DATA_W] = wr_word_p0;
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data_p0[i*DATA_W +: DATA_W] = '0;
                rd_busy_p0[i]                  = 1'b0;
            end
        end
    end

    // Stage p1: register file, scoreboard and read outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy_vec <= '0;
            rd_data  <= '0;
            rd_busy  <= '0;
        end else begin
            if (wr_ok_p0) regs[wr_addr] <= wr_word_p0;
            busy_vec <= busy_next_p0;
            rd_data  <= rd_data_p0;
            rd_busy  <= rd_busy_p0;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: directed vector table on a default instance (ZERO_REG=1),
// reset-mid-traffic sequence, and a 3-port ZERO_REG=0 instance against a reference model.
module tb_regfile_mp_sb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1
    logic        a_reset, a_wr_en, a_sb_set;
    logic [4:0]  a_wr_addr, a_sb_addr;
    logic [31:0] a_wr_data;
    logic [3:0]  a_wr_be;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [31:0] a_busy_vec;

    // Instance B: DATA_W=32, ADDR_W=4, NUM_RD=3, ZERO_REG=0
    logic        b_reset, b_wr_en, b_sb_set;
    logic [3:0]  b_wr_addr, b_sb_addr;
    logic [31:0] b_wr_data;
    logic [3:0]  b_wr_be;
    logic [11:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [15:0] b_busy_vec;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clock(clock), .reset(a_reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .wr_be(a_wr_be), .sb_set(a_sb_set), .sb_addr(a_sb_addr),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy), .busy_vec(a_busy_vec)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clock(clock), .reset(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_be(b_wr_be), .sb_set(b_sb_set), .sb_addr(b_sb_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy), .busy_vec(b_busy_vec)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        sb;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t vecs [11];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                                logic sb, logic [4:0] sa, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [31:0] ebv);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.sb = sb; v.sa = sa;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input vec_t v, input logic rst);
        a_reset   = rst;
        a_wr_en   = v.we;
        a_wr_addr = v.wa;
        a_wr_data = v.wd;
        a_wr_be   = v.be;
        a_sb_set  = v.sb;
        a_sb_addr = v.sa;
        a_rd_addr = {v.ra1, v.ra0};
    endtask

    task automatic check_a(input string tag, input vec_t v);
        chk({tag, "_rd_data"}, 128'(a_rd_data), 128'({v.e1, v.e0}));
        chk({tag, "_rd_busy"}, 128'(a_rd_busy), 128'(v.eb));
        chk({tag, "_busy_vec"}, 128'(a_busy_vec), 128'(v.ebv));
    endtask

    initial begin
        vec_t v;
        logic [95:0] exp_d;
        logic [2:0]  exp_b;
        logic [3:0]  ra;

        vecs[0]  = mk(1, 3,  32'h11223344, 4'hF, 0, 0,  3,  3,  32'h11223344, 32'h11223344, 2'b00, 32'h0);
        vecs[1]  = mk(1, 3,  32'hAABBCCDD, 4'h5, 0, 0,  3,  0,  32'h11BB33DD, 32'h0,        2'b00, 32'h0);
        vecs[2]  = mk(1, 9,  32'h0000CAFE, 4'hF, 0, 0,  9,  9,  32'h0000CAFE, 32'h0000CAFE, 2'b00, 32'h0);
        vecs[3]  = mk(0, 0,  32'h0,        4'h0, 1, 12, 12, 3,  32'h0,        32'h11BB33DD, 2'b01, 32'h1000);
        vecs[4]  = mk(1, 12, 32'h12345678, 4'hF, 0, 0,  12, 12, 32'h12345678, 32'h12345678, 2'b00, 32'h0);
        vecs[5]  = mk(1, 12, 32'h87654321, 4'hF, 1, 12, 12, 9,  32'h87654321, 32'h0000CAFE, 2'b01, 32'h1000);
        vecs[6]  = mk(1, 12, 32'hFFFFFFFF, 4'h0, 0, 0,  12, 12, 32'h87654321, 32'h87654321, 2'b00, 32'h0);
        vecs[7]  = mk(1, 0,  32'hFFFFFFFF, 4'hF, 1, 0,  0,  0,  32'h0,        32'h0,        2'b00, 32'h0);
        vecs[8]  = mk(1, 7,  32'h01020304, 4'h3, 1, 5,  7,  5,  32'h00000304, 32'h0,        2'b10, 32'h20);
        vecs[9]  = mk(1, 5,  32'hDEADBEEF, 4'hF, 0, 0,  5,  3,  32'hDEADBEEF, 32'h11BB33DD, 2'b00, 32'h0);
        vecs[10] = mk(1, 5,  32'hDEADBEEF, 4'hF, 1, 7,  5,  7,  32'hDEADBEEF, 32'h00000304, 2'b10, 32'h80);

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_a(v, 1'b1);
        b_reset = 1'b1; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_be = 0;
        b_sb_set = 0; b_sb_addr = 0; b_rd_addr = 0;
        step();
        step();
        check_a("reset", v);
        chk("reset_b_rd_data", 128'(b_rd_data), 128'(0));
        chk("reset_b_busy", 128'({b_rd_busy, b_busy_vec}), 128'(0));

        a_reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive_a(vecs[i], 1'b0);
            step();
            check_a($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while a write and an issue are pending: reset wins.
        v = mk(1, 5, 32'h55555555, 4'hF, 1, 7, 5, 7, 32'h0, 32'h0, 2'b00, 32'h0);
        drive_a(v, 1'b1);
        step();
        check_a("rst_mid", v);
        v = mk(0, 0, 32'h0, 4'h0, 0, 0, 5, 3, 32'h0, 32'h0, 2'b00, 32'h0);
        drive_a(v, 1'b0);
        step();
        check_a("post_rst", v);

        // Register 0 behaves as a normal register when ZERO_REG=0.
        b_reset = 1'b0;
        b_wr_en = 1; b_wr_addr = 0; b_wr_data = 32'hFFFFFFFF; b_wr_be = 4'hF;
        b_sb_set = 1; b_sb_addr = 0; b_rd_addr = 12'h000;
        step();
        chk("zr0_rd_data", 128'(b_rd_data), 128'({3{32'hFFFFFFFF}}));
        chk("zr0_rd_busy", 128'(b_rd_busy), 128'(3'b111));
        chk("zr0_busy_vec", 128'(b_busy_vec), 128'(16'h0001));
        b_wr_en = 0; b_sb_set = 0;
        step();
        chk("zr0_hold", 128'({b_rd_busy, b_rd_data}), 128'({3'b111, {3{32'hFFFFFFFF}}}));

        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_regs[0] = 32'hFFFFFFFF;
        m_busy    = 16'h0001;

        for (int c = 0; c < 10000; c++) begin
            b_reset   = ($urandom_range(0, 499) == 0);
            b_wr_en   = 1'($urandom_range(0, 1));
            b_wr_addr = 4'($urandom_range(0, 15));
            b_wr_data = $urandom;
            b_wr_be   = 4'($urandom_range(0, 15));
            b_sb_set  = ($urandom_range(0, 3) == 0);
            b_sb_addr = 4'($urandom_range(0, 15));
            b_rd_addr = 12'($urandom_range(0, 4095));

            if (b_reset) begin
                for (int r = 0; r < 16; r++) m_regs[r] = '0;
                m_busy = '0;
            end else begin
                if (b_wr_en) begin
                    for (int k = 0; k < 4; k++)
                        if (b_wr_be[k]) m_regs[b_wr_addr][8*k +: 8] = b_wr_data[8*k +: 8];
                    m_busy[b_wr_addr] = 1'b0;
                end
                if (b_sb_set) m_busy[b_sb_addr] = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                ra = b_rd_addr[4*i +: 4];
                exp_d[32*i +: 32] = m_regs[ra];
                exp_b[i]          = m_busy[ra];
            end

            step();
            chk($sformatf("rnd%0d_rd_data", c), 128'(b_rd_data), 128'(exp_d));
            chk($sformatf("rnd%0d_rd_busy", c), 128'(b_rd_busy), 128'(exp_b));
            chk($sformatf("rnd%0d_busy_vec", c), 128'(b_busy_vec), 128'(m_busy));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
